// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer-side interconnect.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ABORT  = 2'd2
  } apb_ic_state_t;

  // Response driven by the built-in default completer and by the watchdog abort.
  localparam logic DEF_PREADY     = 1'b1;
  localparam logic DEF_PSLVERR    = 1'b1;
  localparam logic DEF_PRDATA_BIT = 1'b0;

  // Wait-state counter width; a disabled watchdog still keeps one bit.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_ic_if.sv
// APB bus bundle: requester side plus the fanned-out completer side.
interface apb_ic_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
) ();
  logic                             PSEL;
  logic                             PENABLE;
  logic [ADDR_WIDTH-1:0]            PADDR;
  logic                             PREADY;
  logic [DATA_WIDTH-1:0]            PRDATA;
  logic                             PSLVERR;
  logic [NUM_SLAVES-1:0]            PSEL_S;
  logic [NUM_SLAVES-1:0]            PREADY_S;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA_S;
  logic [NUM_SLAVES-1:0]            PSLVERR_S;

  // Interconnect view.
  modport slave (
    input  PSEL, PENABLE, PADDR,
    output PREADY, PRDATA, PSLVERR,
    output PSEL_S,
    input  PREADY_S, PRDATA_S, PSLVERR_S
  );

  // Requester and completers view.
  modport master (
    output PSEL, PENABLE, PADDR,
    input  PREADY, PRDATA, PSLVERR,
    input  PSEL_S,
    output PREADY_S, PRDATA_S, PSLVERR_S
  );
endinterface

// File: rtl/apb_addr_decode.sv
// Region index/hit decode and one-hot completer select generation.
import apb_pkg::*;

module apb_addr_decode #(
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W      = 2
) (
  input  logic [IDX_W-1:0]      addr_top,
  output logic [IDX_W-1:0]      idx,
  output logic                  hit,
  input  logic                  sel_vld,
  input  logic [IDX_W-1:0]      sel_idx,
  output logic [NUM_SLAVES-1:0] psel_s
);

  assign idx = addr_top;
  assign hit = ({1'b0, addr_top} < (IDX_W + 1)'(NUM_SLAVES));

  // One-hot select for the chosen completer.
  always_comb begin
    psel_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      psel_s[i] = sel_vld & (sel_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/apb_interconnect.sv
// APB fan-out with default error completer and per-transfer wait-state watchdog.
import apb_pkg::*;

module apb_interconnect #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter int IDX_W      = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_ic_if.slave          bus,
  output logic             timeout_evt,
  output logic [IDX_W-1:0] timeout_idx
);

  localparam int             CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  apb_ic_state_t   state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0] sel_idx_r, sel_idx_nxt_s;
  logic             sel_hit_r, sel_hit_nxt_s;
  logic [IDX_W-1:0] timeout_idx_r, timeout_idx_nxt_s;

  logic [IDX_W-1:0]      idx_s;
  logic                  hit_s;
  logic                  dec_vld_s;
  logic [IDX_W-1:0]      dec_idx_s;
  logic [NUM_SLAVES-1:0] psel_s;

  logic                  slv_ready_s;
  logic                  slv_err_s;
  logic [DATA_WIDTH-1:0] slv_rdata_s;

  logic                  pready_s;
  logic                  pslverr_s;
  logic [DATA_WIDTH-1:0] prdata_s;
  logic                  evt_s;
  logic                  unused_addr_s;

  assign unused_addr_s = ^bus.PADDR[ADDR_WIDTH-IDX_W-1:0];

  apb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr_top (bus.PADDR[ADDR_WIDTH-1 -: IDX_W]),
    .idx      (idx_s),
    .hit      (hit_s),
    .sel_vld  (dec_vld_s),
    .sel_idx  (dec_idx_s),
    .psel_s   (psel_s)
  );

  // Response mux for the latched completer.
  always_comb begin
    slv_ready_s = 1'b0;
    slv_err_s   = 1'b0;
    slv_rdata_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      slv_ready_s = (sel_idx_r == IDX_W'(i)) ? bus.PREADY_S[i]  : slv_ready_s;
      slv_err_s   = (sel_idx_r == IDX_W'(i)) ? bus.PSLVERR_S[i] : slv_err_s;
      slv_rdata_s = (sel_idx_r == IDX_W'(i)) ? bus.PRDATA_S[i*DATA_WIDTH +: DATA_WIDTH] : slv_rdata_s;
    end
  end

  // Next-state, watchdog and requester response.
  always_comb begin
    state_nxt_s       = state_r;
    cnt_nxt_s         = cnt_r;
    sel_idx_nxt_s     = sel_idx_r;
    sel_hit_nxt_s     = sel_hit_r;
    timeout_idx_nxt_s = timeout_idx_r;
    dec_vld_s         = 1'b0;
    dec_idx_s         = idx_s;
    pready_s          = 1'b0;
    pslverr_s         = 1'b0;
    prdata_s          = '0;
    evt_s             = 1'b0;
    case (state_r)
      IDLE: begin
        dec_vld_s = bus.PSEL & hit_s & PRESETn;
        dec_idx_s = idx_s;
        if (bus.PSEL & ~bus.PENABLE) begin
          sel_idx_nxt_s = idx_s;
          sel_hit_nxt_s = hit_s;
          cnt_nxt_s     = '0;
          state_nxt_s   = ACCESS;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          // Requester dropped the transfer: leave silently.
          state_nxt_s = IDLE;
        end else if (!sel_hit_r) begin
          pready_s    = DEF_PREADY;
          pslverr_s   = DEF_PSLVERR;
          prdata_s    = {DATA_WIDTH{DEF_PRDATA_BIT}};
          state_nxt_s = IDLE;
        end else begin
          dec_vld_s = 1'b1;
          dec_idx_s = sel_idx_r;
          pready_s  = slv_ready_s;
          pslverr_s = slv_err_s;
          prdata_s  = slv_rdata_s;
          if (slv_ready_s) begin
            state_nxt_s = IDLE;
          end else if ((TIMEOUT != 0) && (cnt_r == CNT_LAST)) begin
            state_nxt_s = ABORT;
          end else begin
            cnt_nxt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
          end
        end
      end
      ABORT: begin
        pready_s          = DEF_PREADY;
        pslverr_s         = DEF_PSLVERR;
        prdata_s          = {DATA_WIDTH{DEF_PRDATA_BIT}};
        evt_s             = 1'b1;
        timeout_idx_nxt_s = sel_idx_r;
        state_nxt_s       = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, watchdog counter and latched selection.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      sel_idx_r     <= '0;
      sel_hit_r     <= 1'b0;
      timeout_idx_r <= '0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      sel_idx_r     <= sel_idx_nxt_s;
      sel_hit_r     <= sel_hit_nxt_s;
      timeout_idx_r <= timeout_idx_nxt_s;
    end
  end

  assign bus.PSEL_S  = psel_s;
  assign bus.PREADY  = pready_s;
  assign bus.PSLVERR = pslverr_s;
  assign bus.PRDATA  = prdata_s;
  assign timeout_evt = evt_s;
  assign timeout_idx = timeout_idx_r;

endmodule

// File: doc/apb_interconnect.md
# apb_interconnect

Parametrised APB completer-side interconnect that fans a single APB requester out to `NUM_SLAVES` completers. It decodes the completer from the top address bits and returns the selected completer's response. A built-in default completer answers accesses to unmapped regions with `PSLVERR`. A per-transfer watchdog aborts any access phase that exceeds `TIMEOUT` wait states and records which completer timed out. It sits between the AXI-to-APB bridge and the APB peripherals.

## Interface
- `ADDR_WIDTH`, 10: width of PADDR.
- `DATA_WIDTH`, 32: width of PRDATA.
- `NUM_SLAVES`, 4: completer count, 1..2^IDX_W.
- `IDX_W`, 2: number of top PADDR bits used as the region index; `NUM_SLAVES` <= 2^IDX_W.
- `TIMEOUT`, 16: maximum wait states before abort; 0 disables the watchdog.

Ports:
- `PCLK` in 1: clock.
- `PRESETn` in 1: reset. One clock; reset is asynchronous and active-low.
- `PSEL` in 1: requester select.
- `PENABLE` in 1: requester enable.
- `PADDR` in ADDR_WIDTH: requester address.
- `PREADY` out 1: response ready to the requester.
- `PRDATA` out DATA_WIDTH: read data to the requester.
- `PSLVERR` out 1: error to the requester.
- `PSEL_S` out NUM_SLAVES: one-hot completer selects.
- `PREADY_S` in NUM_SLAVES: completer ready, bit i belongs to completer i.
- `PRDATA_S` in NUM_SLAVES*DATA_WIDTH: completer read data, completer i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `PSLVERR_S` in NUM_SLAVES: completer errors.
- `timeout_evt` out 1: one-cycle pulse when a transfer is aborted.
- `timeout_idx` out IDX_W: index of the last completer that timed out.

## Operation
Decode (combinational):
- `idx = PADDR[ADDR_WIDTH-1 -: IDX_W]`.
- `hit = (idx < NUM_SLAVES)`.

The FSM has three states: IDLE, ACCESS, ABORT.

IDLE:
- `PSEL_S = PSEL & hit` one-hot at `idx`. This drives the setup phase.
- `PREADY`, `PSLVERR` and `PRDATA` are 0.
- If `PSEL & !PENABLE`: register `sel_idx <= idx` and `sel_hit <= hit`, clear `cnt`, go to ACCESS.

ACCESS with `sel_hit = 0` (default completer):
- `PSEL_S = 0`, `PREADY = 1`, `PSLVERR = 1`, `PRDATA = 0`.
- Go to IDLE.

ACCESS with `sel_hit = 1`:
- `PSEL_S` is one-hot at `sel_idx`.
- `PREADY`, `PRDATA` and `PSLVERR` are forwarded from completer `sel_idx`.
- If the completer's `PREADY_S` is 1: go to IDLE.
- Else if `TIMEOUT != 0` and `cnt == TIMEOUT-1`: go to ABORT.
- Else: `cnt <= cnt + 1`.

ABORT:
- `PSEL_S = 0`, `PREADY = 1`, `PSLVERR = 1`, `PRDATA = 0`.
- `timeout_evt = 1`, `timeout_idx <= sel_idx`.
- Go to IDLE.

Protocol guard: if `PSEL` is 0 while in ACCESS, go straight to IDLE with no response and no event.

Widths:
- `cnt` is `$clog2(TIMEOUT+1)` bits and saturates; it never wraps.
- `PSLVERR` forwarded from a completer is passed through unchanged, including when `PREADY_S` is 0.

Back-to-back transfers: the cycle after a completion is handled in IDLE, so a new setup phase can start immediately with no bubble.

## Timing
- Reset values: state IDLE, `cnt` 0, `sel_idx` 0, `sel_hit` 0, `timeout_idx` 0, `timeout_evt` 0.
- While `PRESETn` is 0, all outputs are 0, including `PSEL_S`, which is gated by `PRESETn`.
- Latency through the block is zero: the decode and the response mux are combinational and add no wait states.
- Unmapped access: completes in the first access cycle with 0 wait states.
- Timeout: for a completer holding `PREADY_S` at 0, the access cycles 1..TIMEOUT show `PREADY = 0`. Cycle TIMEOUT+1 is ABORT, so the requester sees exactly TIMEOUT wait states.
- If `PREADY_S` rises in the same cycle as the `cnt == TIMEOUT-1` check, completion wins and no abort occurs.
- Asynchronous reset mid-transfer: the state returns to IDLE immediately and any pending abort is discarded.

## Structure
- Package `apb_pkg` holds the state enum `apb_ic_state_t` (IDLE, ACCESS, ABORT) and the localparams for the counter width and the default-completer response values.
- Sub-module `apb_addr_decode` holds the parametrised index/hit decode and the one-hot `PSEL_S` generation.
- The FSM, watchdog and response mux live in the top level.

## Test plan
- **Mapped read.** Defaults, `PADDR = 10'h100` (idx 1), `PREADY_S[1] = 1` on the first access cycle with data `32'hCAFE_0001` → `PSEL_S = 4'b0010`, `PRDATA = 32'hCAFE_0001`, `PREADY = 1`, 0 wait states.
- **Unmapped region.** `NUM_SLAVES = 3`, `PADDR = 10'h300` → `PSEL_S = 0` throughout, `PREADY = 1` and `PSLVERR = 1` in the first access cycle, `PRDATA = 0`.
- **Timeout.** `TIMEOUT = 4`, completer 2 never ready → 4 access cycles with `PREADY = 0`, then `PREADY = 1` and `PSLVERR = 1`, `timeout_evt` pulses once, `timeout_idx = 2`, `PSEL_S[2]` drops in the ABORT cycle.
- **Boundary ready.** `TIMEOUT = 4`, `PREADY_S` rises on the 4th access cycle → normal completion, `PSLVERR` follows the completer, no `timeout_evt`.
- **Back-to-back and error forwarding.** Transfers to idx 0 then idx 3 with no idle cycle between them, then completer 0 returns `PSLVERR_S = 1` → selects switch cleanly with no overlap and `PSLVERR` is forwarded.
- **Reset mid-transfer.** Assert `PRESETn = 0` during a wait state → `PSEL_S`, `PREADY` and `timeout_evt` go to 0 at once, and state is IDLE after release.
